// File: rtl/camera_read_pkg.sv
// Shared definitions for the OV7670 parallel capture front end.
package camera_read_pkg;

  // Capture FSM states.
  typedef enum logic {
    WAIT_FRAME_START = 1'b0,
    ROW_CAPTURE      = 1'b1
  } cam_state_t;

  // Default counter widths for a 640x480 frame.
  localparam int CAM_X_W = 10;
  localparam int CAM_Y_W = 9;

  // True on the sample where a level was high last cycle and is low now.
  function automatic logic fell(input logic prev, input logic cur);
    return prev & ~cur;
  endfunction

endpackage : camera_read_pkg

// File: rtl/camera_read.sv
// OV7670 capture front end: frames the byte stream with vsync/href and packs
// byte pairs into 16-bit pixels with their column/row coordinates.
//
// Output protocol: there is no back-pressure. pixel_valid is a one-cycle
// strobe; pixel_data, pixel_x and pixel_y are meaningful in that cycle and
// hold until the next update. frame_done is a one-cycle strobe and is never
// high in the same cycle as pixel_valid.
module camera_read
  import camera_read_pkg::*;
#(
  parameter int X_W = CAM_X_W,
  parameter int Y_W = CAM_Y_W
) (
  input  logic           p_clock,
  input  logic           reset,
  input  logic           vsync,
  input  logic           href,
  input  logic [7:0]     p_data,
  output logic [15:0]    pixel_data,
  output logic           pixel_valid,
  output logic           frame_done,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y
);

  // FSM state is kept as a named enum so checkers can bind to it.
  cam_state_t     state;
  logic           vsync_d;
  logic           href_d;
  logic           toggle;          // 1: high byte of a pair already captured
  logic           line_has_pixel;  // current line emitted at least one pixel
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;

  logic frame_start;
  logic href_fall;

  assign frame_start = fell(vsync_d, vsync);
  assign href_fall   = fell(href_d, href);

  // One-cycle delayed copies of the sync inputs for edge detection.
  always_ff @(posedge p_clock) begin
    if (reset) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      vsync_d <= vsync;
      href_d  <= href;
    end
  end

  // Capture FSM: framing, byte packing, coordinate counters, registered outputs.
  always_ff @(posedge p_clock) begin
    if (reset) begin
      state          <= WAIT_FRAME_START;
      toggle         <= 1'b0;
      line_has_pixel <= 1'b0;
      x              <= '0;
      y              <= '0;
      pixel_data     <= 16'h0000;
      pixel_valid    <= 1'b0;
      frame_done     <= 1'b0;
      pixel_x        <= '0;
      pixel_y        <= '0;
    end else begin
      // Strobes default low; they are raised for exactly one cycle below.
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        WAIT_FRAME_START: begin
          // href is ignored here; bytes on the start edge are not captured.
          if (frame_start) begin
            state          <= ROW_CAPTURE;
            toggle         <= 1'b0;
            line_has_pixel <= 1'b0;
            x              <= '0;
            y              <= '0;
          end
        end
        ROW_CAPTURE: begin
          if (vsync) begin
            // End of frame wins over href; any half pixel is dropped.
            frame_done <= 1'b1;
            toggle     <= 1'b0;
            state      <= WAIT_FRAME_START;
          end else if (href) begin
            if (!toggle) begin
              pixel_data[15:8] <= p_data;
              toggle           <= 1'b1;
            end else begin
              pixel_data[7:0] <= p_data;
              pixel_valid     <= 1'b1;
              pixel_x         <= x;
              pixel_y         <= y;
              x               <= x + X_W'(1);
              line_has_pixel  <= 1'b1;
              toggle          <= 1'b0;
            end
          end else if (href_fall) begin
            // End of line: drop a stray half pixel, move to the next row only
            // if this line actually produced pixels.
            toggle         <= 1'b0;
            x              <= '0;
            line_has_pixel <= 1'b0;
            if (line_has_pixel) begin
              y <= y + Y_W'(1);
            end
          end
        end
        default: begin
          state <= WAIT_FRAME_START;
        end
      endcase
    end
  end

endmodule : camera_read

// File: tb/tb_camera_read.sv
// Self-checking bench for camera_read: directed scenarios plus randomized
// frames, checked cycle by cycle against a byte-queue reference model.
module tb_camera_read;

  localparam int X_W   = 4;
  localparam int Y_W   = 3;
  localparam int REC_W = Y_W + X_W + 16;

  logic           p_clock = 1'b0;
  logic           reset   = 1'b1;
  logic           vsync   = 1'b0;
  logic           href    = 1'b0;
  logic [7:0]     p_data  = 8'h00;
  logic [15:0]    pixel_data;
  logic           pixel_valid;
  logic           frame_done;
  logic [X_W-1:0] pixel_x;
  logic [Y_W-1:0] pixel_y;

  camera_read #(.X_W(X_W), .Y_W(Y_W)) dut (
    .p_clock     (p_clock),
    .reset       (reset),
    .vsync       (vsync),
    .href        (href),
    .p_data      (p_data),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .frame_done  (frame_done),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y)
  );

  // Clock
  always #5 p_clock = ~p_clock;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [REC_W-1:0] rec(input int yy, input int xx, input logic [15:0] d);
    return {Y_W'(yy), X_W'(xx), d};
  endfunction

  // Reference model: tracks whether a frame is open, the bytes collected for
  // the pixel in progress, and column/row counts as plain integers.
  bit          m_in_frame;
  bit          m_prev_v, m_prev_h;
  logic [7:0]  m_bytes[$];
  int          m_col, m_row, m_line_pixels;
  logic [15:0] m_data;
  logic [X_W-1:0] m_x;
  logic [Y_W-1:0] m_y;
  bit          m_valid, m_done;

  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] got_q[$];
  int               done_cnt;

  task automatic model_step(input logic r, input logic v, input logic h, input logic [7:0] d);
    m_valid = 0;
    m_done  = 0;
    if (r) begin
      m_in_frame = 0; m_prev_v = 0; m_prev_h = 0;
      m_bytes.delete();
      m_col = 0; m_row = 0; m_line_pixels = 0;
      m_data = 16'h0000; m_x = '0; m_y = '0;
      return;
    end
    if (!m_in_frame) begin
      if (m_prev_v && !v) begin
        m_in_frame = 1;
        m_bytes.delete();
        m_col = 0; m_row = 0; m_line_pixels = 0;
      end
    end else if (v) begin
      m_done = 1;
      m_in_frame = 0;
      m_bytes.delete();
    end else if (h) begin
      m_bytes.push_back(d);
      if (m_bytes.size() == 1) begin
        m_data[15:8] = d;
      end else begin
        m_data  = {m_bytes[0], m_bytes[1]};
        m_valid = 1;
        m_x = X_W'(m_col % (1 << X_W));
        m_y = Y_W'(m_row % (1 << Y_W));
        exp_q.push_back({m_y, m_x, m_data});
        m_col++;
        m_line_pixels++;
        m_bytes.delete();
      end
    end else if (m_prev_h) begin
      m_bytes.delete();
      m_col = 0;
      if (m_line_pixels > 0) m_row++;
      m_line_pixels = 0;
    end
    m_prev_v = v;
    m_prev_h = h;
  endtask

  // Driver: apply inputs on the falling edge, step the model on the rising
  // edge, compare registered outputs just after it.
  task automatic cyc(input logic r, input logic v, input logic h, input logic [7:0] d);
    @(negedge p_clock);
    reset = r; vsync = v; href = h; p_data = d;
    @(posedge p_clock);
    model_step(r, v, h, d);
    #1;
    check("valid", 64'(pixel_valid), 64'(m_valid));
    check("done",  64'(frame_done),  64'(m_done));
    check("data",  64'(pixel_data),  64'(m_data));
    check("x",     64'(pixel_x),     64'(m_x));
    check("y",     64'(pixel_y),     64'(m_y));
    if (pixel_valid && exp_q.size() > 0)
      check("pix", 64'({pixel_y, pixel_x, pixel_data}), 64'(exp_q.pop_front()));
    exp_q.delete();
    if (pixel_valid) got_q.push_back({pixel_y, pixel_x, pixel_data});
    if (frame_done) done_cnt++;
  endtask

  // Send n bytes (most significant first) with href high, then one href-low cycle.
  task automatic line(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, bytes[8*(n-1-i) +: 8]);
    cyc(0, 0, 0, 8'h00);
  endtask

  task automatic start_frame();
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
  endtask

  task automatic clear_log();
    got_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    model_step(1, 0, 0, 8'h00);
    // Reset and reset values
    cyc(1, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
    check("rst_data",  64'(pixel_data),  64'h0);
    check("rst_valid", 64'(pixel_valid), 64'h0);
    check("rst_x",     64'(pixel_x),     64'h0);

    // No capture before any frame start
    clear_log();
    for (int i = 0; i < 8; i++) cyc(0, 0, i[0], 8'(8'h30 + i));
    check("pre_n",    64'(got_q.size()), 64'd0);
    check("pre_data", 64'(pixel_data),   64'h0);

    // Basic pixel
    clear_log();
    start_frame();
    line(64'hFF00, 2);
    check("basic_n",    64'(got_q.size()), 64'd1);
    check("basic_pix",  64'(got_q[0]),     64'(rec(0, 0, 16'hFF00)));
    check("basic_done", 64'(done_cnt),     64'd0);

    // Line of 4 pixels; href already high on the start edge (byte 77 dropped)
    clear_log();
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 1, 8'h77);
    line(64'h123456789ABCDEF0, 8);
    line(64'h5566, 2);
    check("l4_n",    64'(got_q.size()), 64'd5);
    check("l4_p0",   64'(got_q[0]), 64'(rec(0, 0, 16'h1234)));
    check("l4_p1",   64'(got_q[1]), 64'(rec(0, 1, 16'h5678)));
    check("l4_p2",   64'(got_q[2]), 64'(rec(0, 2, 16'h9ABC)));
    check("l4_p3",   64'(got_q[3]), 64'(rec(0, 3, 16'hDEF0)));
    check("l4_next", 64'(got_q[4]), 64'(rec(1, 0, 16'h5566)));
    check("l4_done", 64'(done_cnt), 64'd1);

    // Frame end; href bytes while vsync stays high are ignored
    clear_log();
    cyc(0, 1, 0, 8'h00);
    check("end_pulse", 64'(frame_done), 64'd1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 8'(8'hE0 + i));
    check("end_once", 64'(done_cnt),     64'd1);
    check("end_npix", 64'(got_q.size()), 64'd0);

    // Odd byte line: trailing CC dropped but left in the high byte
    clear_log();
    cyc(0, 0, 0, 8'h00);
    line(64'hAABBCC, 3);
    check("odd_stale", 64'(pixel_data), 64'hCCBB);
    line(64'h1122, 2);
    check("odd_n",  64'(got_q.size()), 64'd2);
    check("odd_p0", 64'(got_q[0]), 64'(rec(0, 0, 16'hAABB)));
    check("odd_p1", 64'(got_q[1]), 64'(rec(1, 0, 16'h1122)));

    // Reset mid-line, then a clean frame
    clear_log();
    cyc(0, 0, 1, 8'h5A);
    cyc(1, 0, 1, 8'h6B);
    check("mrst_data", 64'(pixel_data), 64'h0);
    check("mrst_y",    64'(pixel_y),    64'h0);
    start_frame();
    line(64'hA1B2, 2);
    check("mrst_n",   64'(got_q.size()), 64'd1);
    check("mrst_pix", 64'(got_q[0]), 64'(rec(0, 0, 16'hA1B2)));

    // Randomized frames with counter wrap and occasional resets
    for (int f = 0; f < 30; f++) begin
      int nv = $urandom_range(1, 3);
      for (int i = 0; i < nv; i++) cyc(0, 1, 1'($urandom_range(0, 1)), 8'($urandom));
      cyc(0, 0, 1'($urandom_range(0, 1)), 8'($urandom));
      for (int l = 0; l < int'($urandom_range(0, 10)); l++) begin
        int gap = $urandom_range(1, 3);
        int nb  = $urandom_range(0, 40);
        for (int g = 0; g < gap; g++) cyc(0, 0, 0, 8'($urandom));
        for (int b = 0; b < nb; b++)
          cyc($urandom_range(0, 299) == 0, 0, 1, 8'($urandom));
      end
    end

    // Fully random pin activity
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
          1'($urandom_range(0, 1)), 8'($urandom));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_camera_read

// File: doc/camera_read.md
# camera_read

Capture front end for the OV7670 camera's 8-bit parallel pixel bus. It sits directly behind the sensor pins in the `p_clock` domain. It frames the byte stream using `vsync`/`href` and packs byte pairs into 16-bit pixels, e.g. RGB565. It emits one-cycle `pixel_valid` and `frame_done` strobes, plus pixel coordinates, for a downstream frame buffer or writer.

## Interface
Parameters:
- `X_W`, default 10: width of the column counter (640 px).
- `Y_W`, default 9: width of the row counter (480 lines).

Ports:
- `p_clock`  in  1  sensor pixel clock; the only clock; all logic on rising edge.
- `reset`  in  1  reset; one clock; reset is synchronous and active-high.
- `vsync`  in  1  frame sync from sensor; high between frames.
- `href`  in  1  line-valid from sensor; high while row bytes are on `p_data`.
- `p_data`  in  8  sensor data byte.
- `pixel_data`  out  16  last assembled pixel: first byte of a pair in [15:8], second byte in [7:0].
- `pixel_valid`  out  1  one-cycle strobe; `pixel_data` holds a complete new pixel.
- `frame_done`  out  1  one-cycle strobe at end of frame.
- `pixel_x`  out  X_W  column of the pixel flagged by `pixel_valid`.
- `pixel_y`  out  Y_W  row of the pixel flagged by `pixel_valid`.

## Operation
- Inputs are sampled on the rising edge of `p_clock`.
- `vsync_d` is a 1-cycle delayed copy of `vsync`, used for edge detection.
- State machine with states WAIT_FRAME_START and ROW_CAPTURE:
  - WAIT_FRAME_START: `href` is ignored. On a vsync falling edge (`vsync_d`=1, `vsync`=0), go to ROW_CAPTURE and clear the byte toggle, `x` and `y`.
  - ROW_CAPTURE, when `vsync`=1: pulse `frame_done`, discard any half pixel, return to WAIT_FRAME_START.
  - ROW_CAPTURE, when `href`=1 and `vsync`=0:
    - toggle=0: load `p_data` into `pixel_data[15:8]`; set toggle to 1.
    - toggle=1: load `p_data` into `pixel_data[7:0]`; pulse `pixel_valid`; present the current `x`/`y` on `pixel_x`/`pixel_y`; then increment `x`; set toggle to 0.
  - ROW_CAPTURE, on an href falling edge: clear the toggle; reset `x` to 0; increment `y` if the line produced at least one pixel.
- Counters wrap modulo 2^width; there is no saturation or error output.
- An odd byte count on a line leaves a half pixel. It is discarded: no `pixel_valid`, and `pixel_data[15:8]` keeps the stale byte.
- `pixel_data` holds its value between strobes.

## Timing
- Reset values: state=WAIT_FRAME_START, toggle=0, `vsync_d`=0, `pixel_data`=16'h0000, `pixel_valid`=0, `frame_done`=0, `pixel_x`=0, `pixel_y`=0. Reset overrides everything, including mid-frame.
- All outputs are registered.
- `pixel_valid` is high for exactly the one cycle after the edge that sampled the second byte. `pixel_data` and coordinates are valid in that same cycle.
- `frame_done` is high for exactly the one cycle after the edge that sampled `vsync`=1 in ROW_CAPTURE.
- Latency from second byte sampled to `pixel_valid` high: 1 cycle.
- Frame start is recognised on the edge that samples `vsync` low after a sampled high. Bytes on that same edge are not captured.
- The first `href`-high sample in the following cycle is captured.
- Strobes never overlap: `vsync`=1 takes priority over `href`.
- No back-pressure; downstream logic must accept one pixel every 2 cycles.

## Structure
- Shared camera package holds the state enum (WAIT_FRAME_START, ROW_CAPTURE) and the default `X_W`/`Y_W` constants.
- Single module; no sub-modules.
- The edge detector is inline logic.

## Test plan
- Basic pixel: reset; `vsync` 1 for 1 cycle then 0; `href`=1 with `p_data`=FF then 00; `href`=0 -> one `pixel_valid` pulse with `pixel_data`=16'hFF00, `pixel_x`=0, `pixel_y`=0; `frame_done` stays 0.
- Line of 4 pixels (bytes 12 34 56 78 9A BC DE F0) -> valid pulses with 1234 @x0, 5678 @x1, 9ABC @x2, DEF0 @x3. The next line's first pixel reports `pixel_y`=1, `pixel_x`=0.
- Frame end: `vsync` rises during ROW_CAPTURE -> single-cycle `frame_done`; state returns to WAIT_FRAME_START; `href` bytes afterwards produce no `pixel_valid` until the next vsync falling edge.
- Odd byte line: 3 bytes AA BB CC, then `href` low; next line 11 22 -> valid for AABB, then 1122 at `pixel_x`=0. The CC byte is never reported.
- Before any frame start: `href` toggling with data -> no `pixel_valid`, all outputs at reset values.
- Reset mid-line after the first byte -> all outputs return to reset values next cycle; a subsequent full frame captures correctly from x=0, y=0.
